mesm6_alu_arb: RTL and testbench
================================

// Module: mesm6_alu_arb
// PURPOSE
//  Two-port arbiter/sequencer sharing one mesm6_alu between requesters.
//  Port 0 is the fetch/address unit; port 1 is the execute unit.
//  - Accepts one operation at a time, round-robin between ports.
//  - Drives the ALU until alu_done, registers the result, returns it to the
//    granting port over a valid/ready response.
//  - Watchdog returns an error if alu_done never arrives.
// PARAMETERS
//  DW       48              data width of alu_a/alu_b/alu_r
//  OPW      `ALU_OP_WIDTH   ALU opcode width
//  TIMEOUT  16              max BUSY cycles waiting for alu_done; 0 = watchdog off
// PORTS
//  clk          in   1    clock; all state changes on posedge
//  reset        in   1    synchronous, active-high reset
//  req_valid0/1 in   1    request valid, per port
//  req_ready0/1 out  1    request accepted this cycle (comb, IDLE only)
//  req_a0/1     in   DW   operand A, per port
//  req_b0/1     in   DW   operand B, per port
//  req_op0/1    in   OPW  ALU opcode, per port
//  resp_valid0/1 out 1    response valid, per port
//  resp_ready0/1 in  1    requester takes the response
//  resp_data    out  DW   registered result, shared by both ports
//  resp_err     out  1    1 = watchdog expired, resp_data = 0
//  alu_a, alu_b out  DW   to ALU operands
//  alu_op       out  OPW  to ALU opcode
//  alu_r        in   DW   from ALU result
//  alu_done     in   1    from ALU done
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  Reset:
//  - state=IDLE, last_grant=1 (port 0 wins first tie), wait_cnt=0.
//  - resp_data=0, resp_err=0, operand/op regs=0.
//  - All resp_valid=0, all req_ready=0.
//  - alu_op=`ALU_NOP, alu_a=alu_b=0, busy=0.
//  - Reset in any state aborts the operation; any pending response is dropped.
//  FSM IDLE -> BUSY -> RESP -> IDLE
//  IDLE:
//  - Winner is the only valid port, or, if both are valid, the port != last_grant.
//  - req_ready=1 for the winner only. On the edge, latch a/b/op, set last_grant,
//    clear wait_cnt, go to BUSY.
//  BUSY:
//  - alu_a/alu_b/alu_op driven from the latched registers; no req_ready.
//  - alu_done=1: resp_data<=alu_r, resp_err<=0, go to RESP.
//  - Else, if TIMEOUT!=0 and wait_cnt==TIMEOUT-1: resp_data<=0, resp_err<=1,
//    go to RESP.
//  - Else wait_cnt<=wait_cnt+1.
//  - alu_done wins over timeout in the same cycle.
//  RESP:
//  - resp_valid=1 for last_grant port only; resp_data/resp_err held stable.
//  - Leave to IDLE on the edge where that port's resp_ready=1.
//  - Requests are not accepted in RESP, even on the resp_ready cycle.
//  Outside BUSY: alu_op=`ALU_NOP; alu_a/alu_b keep the latched values.
//  Latency:
//  - Accept at edge N with alu_done=1 in the first BUSY cycle -> resp_valid
//    is high after edge N+1.
//  - Minimum issue interval is 3 cycles.
//  Widths:
//  - wait_cnt is $clog2(TIMEOUT+1) bits and never wraps.
//  - Data is passed through unmodified; no arithmetic is done here.
//  A req_valid drop while unselected is legal; there is no queueing.
// TESTING
//  1 Reset, then port0 req a=5 b=7 op=ALU_AND, alu_done=1 -> ready0 at
//    accept; resp_valid0 one cycle later; resp_data=5; err=0.
//  2 Both ports valid from reset, stalls off -> grants 0,1,0,1 alternate;
//    each resp goes only to the granted port.
//  3 Stub alu_done low 3 cycles, TIMEOUT=16 -> resp after 4 BUSY cycles;
//    resp_data=alu_r; err=0.
//  4 alu_done stuck 0, TIMEOUT=16 -> exactly 16 BUSY cycles, then resp_err=1
//    and resp_data=0; TIMEOUT=0 -> stays BUSY indefinitely.
//  5 Hold resp_ready1=0 for 5 cycles with port0 valid -> resp_valid1 and
//    data stable; no ready0 until after RESP->IDLE.
//  6 Assert reset in BUSY and again in RESP -> next cycle IDLE, all outputs at
//    reset values, no resp_valid; port0 wins the next tie.

Source files
------------

// File: rtl/mesm6_alu_arb.sv
// mesm6_alu_arb
//   Shares one mesm6_alu between two requesters. Port 0 is the fetch/address
//   unit and port 1 is the execute unit. One operation is in flight at a time.
//   Ports are served round-robin. The ALU is driven until alu_done, and the
//   registered result goes back to the granting port. A watchdog turns a
//   missing alu_done into an error response.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_valid0/1, req_ready0/1  request handshake, per port
//   req_a0/1, req_b0/1, req_op0/1  operands and opcode, per port
//   resp_valid0/1, resp_ready0/1   response handshake, per port
//   resp_data, resp_err         shared registered result / watchdog flag
//   alu_a, alu_b, alu_op        to the ALU
//   alu_r, alu_done             from the ALU
//   busy                        operation in flight (state != IDLE)
//   state_dbg                   current FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is combinational and is only offered in IDLE, to the
// arbitration winner. resp_valid is high only in RESP, for the granted port.
// resp_data/resp_err stay stable until that port's resp_ready is seen.

`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_NOP
`define ALU_NOP 0
`endif

module mesm6_alu_arb #(
  parameter int DW      = 48,
  parameter int OPW     = `ALU_OP_WIDTH,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           req_valid0,
  input  logic           req_valid1,
  output logic           req_ready0,
  output logic           req_ready1,
  input  logic [DW-1:0]  req_a0,
  input  logic [DW-1:0]  req_a1,
  input  logic [DW-1:0]  req_b0,
  input  logic [DW-1:0]  req_b1,
  input  logic [OPW-1:0] req_op0,
  input  logic [OPW-1:0] req_op1,
  output logic           resp_valid0,
  output logic           resp_valid1,
  input  logic           resp_ready0,
  input  logic           resp_ready1,
  output logic [DW-1:0]  resp_data,
  output logic           resp_err,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_r,
  input  logic           alu_done,
  output logic           busy,
  output logic [1:0]     state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // A zero-width counter is illegal, so a disabled watchdog still keeps one bit.
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] WAIT_MAX  = {CW{1'b1}};
  localparam logic [OPW-1:0] OP_NOP   = OPW'(`ALU_NOP);

  state_t         state, next_state;
  logic           last_grant;
  logic [CW-1:0]  wait_cnt;
  logic [DW-1:0]  a_q, b_q;
  logic [OPW-1:0] op_q;

  logic           any_req;
  logic           winner;
  logic           accept;
  logic           timeout_hit;
  logic           resp_take;

  // The port that was not served last wins a tie. Otherwise the only valid
  // port wins.
  always_comb begin
    any_req = req_valid0 | req_valid1;
    if (req_valid0 && req_valid1) begin
      winner = ~last_grant;
    end else begin
      winner = req_valid1;
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);
  assign resp_take   = last_grant ? resp_ready1 : resp_ready0;

  // Next-state and handshake outputs. Reset gates the handshakes, so nothing
  // looks accepted or offered during a reset cycle.
  always_comb begin
    next_state  = state;
    req_ready0  = 1'b0;
    req_ready1  = 1'b0;
    resp_valid0 = 1'b0;
    resp_valid1 = 1'b0;
    accept      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (any_req && !reset) begin
          accept     = 1'b1;
          req_ready0 = ~winner;
          req_ready1 = winner;
          next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (alu_done || timeout_hit) begin
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        resp_valid0 = ~last_grant & ~reset;
        resp_valid1 = last_grant & ~reset;
        if (resp_take) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        last_grant <= winner;
        wait_cnt   <= '0;
        a_q        <= winner ? req_a1 : req_a0;
        b_q        <= winner ? req_b1 : req_b0;
        op_q       <= winner ? req_op1 : req_op0;
      end
      if (state == S_BUSY) begin
        // alu_done takes priority over the watchdog in the same cycle.
        if (alu_done) begin
          resp_data <= alu_r;
          resp_err  <= 1'b0;
        end else if (timeout_hit) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end else if (wait_cnt != WAIT_MAX) begin
          // With the watchdog off, the counter saturates instead of wrapping.
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

  // The operands stay on the latched values at all times. The opcode is live
  // only in BUSY, so the ALU sees a NOP whenever it is not in use.
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = (state == S_BUSY) ? op_q : OP_NOP;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mesm6_alu_arb.sv
// Bench for mesm6_alu_arb: directed scenarios followed by randomized transactions,
// checked against a transaction-level model of arbitration, latency and watchdog.
module tb_mesm6_alu_arb;
  localparam int DW  = 48;
  localparam int OPW = 4;
  localparam int TO  = 16;
  localparam logic [OPW-1:0] OP_AND = 4'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           req_valid0, req_valid1, resp_ready0, resp_ready1, alu_done;
  logic [DW-1:0]  req_a0, req_a1, req_b0, req_b1;
  logic [OPW-1:0] req_op0, req_op1;
  logic           req_ready0, req_ready1, resp_valid0, resp_valid1, resp_err, busy;
  logic [DW-1:0]  resp_data, alu_a, alu_b, alu_r;
  logic [OPW-1:0] alu_op;
  logic [1:0]     state_dbg;

  // second instance, watchdog disabled
  logic           z_valid;
  logic           z_ready0, z_ready1, z_resp_valid0, z_resp_valid1, z_err, z_busy;
  logic [DW-1:0]  z_data, z_alu_a, z_alu_b;
  logic [OPW-1:0] z_alu_op;
  logic [1:0]     z_state;

  int total = 0;
  int bad   = 0;
  int last_g;                // model: last granted port
  logic [DW-1:0] exp_q[$];   // scoreboard of expected response data

  function automatic logic [DW-1:0] alu_model(input logic [DW-1:0] a, b,
                                              input logic [OPW-1:0] op);
    case (op)
      4'd1: return a & b;
      4'd2: return a | b;
      4'd3: return a ^ b;
      4'd4: return a + b;
      default: return a;
    endcase
  endfunction

  // ALU stub: combinational result, done under bench control
  assign alu_r = alu_model(alu_a, alu_b, alu_op);

  mesm6_alu_arb #(.DW(DW), .OPW(OPW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(req_ready0), .req_ready1(req_ready1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .resp_valid0(resp_valid0), .resp_valid1(resp_valid1),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_done(alu_done), .busy(busy), .state_dbg(state_dbg)
  );

  mesm6_alu_arb #(.DW(DW), .OPW(OPW), .TIMEOUT(0)) u_dut_nowd (
    .clk(clk), .reset(reset),
    .req_valid0(z_valid), .req_valid1(1'b0),
    .req_ready0(z_ready0), .req_ready1(z_ready1),
    .req_a0(48'h123), .req_a1('0), .req_b0(48'h456), .req_b1('0),
    .req_op0(4'd2), .req_op1('0),
    .resp_valid0(z_resp_valid0), .resp_valid1(z_resp_valid1),
    .resp_ready0(1'b1), .resp_ready1(1'b1),
    .resp_data(z_data), .resp_err(z_err),
    .alu_a(z_alu_a), .alu_b(z_alu_b), .alu_op(z_alu_op),
    .alu_r(48'hABC), .alu_done(1'b0), .busy(z_busy), .state_dbg(z_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_dw();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic clear_inputs();
    req_valid0 = 0; req_valid1 = 0; resp_ready0 = 0; resp_ready1 = 0; alu_done = 0;
  endtask

  // Called at a negedge: hold reset over one edge, then check reset values.
  task automatic reset_check();
    reset = 1'b1;
    #1;
    chk("rst_cycle_ready", {req_ready1, req_ready0}, 0);
    chk("rst_cycle_resp_valid", {resp_valid1, resp_valid0}, 0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", {resp_valid1, resp_valid0}, 0);
    chk("rst_req_ready", {req_ready1, req_ready0}, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    last_g = 1;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // One transaction: offer requests in IDLE, run d+1 BUSY cycles (alu_done
  // after d cycles) or the full watchdog, then hold the response for
  // 'stall' extra cycles. abort=1/2 applies reset in BUSY/RESP instead.
  task automatic txn(input bit v0, v1, input int d, stall, abort,
                     input logic [DW-1:0] a0, b0, a1, b1,
                     input logic [OPW-1:0] op0, op1);
    int w, nbusy;
    bit exp_err;
    logic [DW-1:0] wa, wb;
    logic [OPW-1:0] wop;
    @(negedge clk);
    req_valid0 = v0; req_valid1 = v1;
    req_a0 = a0; req_b0 = b0; req_op0 = op0;
    req_a1 = a1; req_b1 = b1; req_op1 = op1;
    alu_done = 0; resp_ready0 = 0; resp_ready1 = 0;
    #1;
    w = (v0 && v1) ? 1 - last_g : (v1 ? 1 : 0);
    chk("idle_busy", busy, 0);
    chk("ready0", req_ready0, v0 && (w == 0));
    chk("ready1", req_ready1, v1 && (w == 1));
    chk("idle_resp_valid", {resp_valid1, resp_valid0}, 0);
    wa = (w == 1) ? a1 : a0;
    wb = (w == 1) ? b1 : b0;
    wop = (w == 1) ? op1 : op0;
    exp_err = (d >= TO);
    exp_q.push_back(exp_err ? '0 : alu_model(wa, wb, wop));
    last_g = w;
    nbusy = exp_err ? TO : d + 1;
    for (int k = 0; k < nbusy; k++) begin
      @(negedge clk);
      req_valid0 = 1'($urandom_range(0, 1));
      req_valid1 = 1'($urandom_range(0, 1));
      alu_done = (k == d);
      if (abort == 1) begin
        reset_check();
        return;
      end
      #1;
      chk("busy_busy", busy, 1);
      chk("busy_alu_op", alu_op, wop);
      chk("busy_alu_a", alu_a, wa);
      chk("busy_alu_b", alu_b, wb);
      chk("busy_req_ready", {req_ready1, req_ready0}, 0);
      chk("busy_resp_valid", {resp_valid1, resp_valid0}, 0);
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      alu_done = 0;
      // the other port keeps requesting; it must not be accepted
      req_valid0 = (w == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      req_valid1 = (w == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      resp_ready0 = (w == 0) ? (s == stall) : 1'($urandom_range(0, 1));
      resp_ready1 = (w == 1) ? (s == stall) : 1'($urandom_range(0, 1));
      if (abort == 2) begin
        reset_check();
        return;
      end
      #1;
      chk("resp_valid_granted", w ? resp_valid1 : resp_valid0, 1);
      chk("resp_valid_other", w ? resp_valid0 : resp_valid1, 0);
      chk("resp_data", resp_data, exp_q[0]);
      chk("resp_err", resp_err, exp_err);
      chk("resp_req_ready", {req_ready1, req_ready0}, 0);
      chk("resp_alu_op_nop", alu_op, 0);
      chk("resp_alu_a_held", alu_a, wa);
    end
    void'(exp_q.pop_front());
  endtask

  task automatic txn_rand(input bit v0, v1, input int d, stall, abort);
    txn(v0, v1, d, stall, abort, rnd_dw(), rnd_dw(), rnd_dw(), rnd_dw(),
        4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    z_valid = 0;
    req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0; req_op0 = '0; req_op1 = '0;
    last_g = 1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_check();

    // watchdog disabled: stays BUSY with alu_done stuck low
    @(negedge clk);
    z_valid = 1;
    #1;
    chk("nowd_ready0", z_ready0, 1);
    @(negedge clk);
    z_valid = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk("nowd_busy", z_busy, 1);
      chk("nowd_no_resp", z_resp_valid0, 0);
      @(negedge clk);
    end

    // first op: port 0, AND of 5 and 7, done immediately
    txn(1, 0, 0, 0, 0, 48'd5, 48'd7, '0, '0, OP_AND, 4'd0);

    // both valid from reset: grants alternate starting with port 0
    @(negedge clk);
    reset_check();
    for (int i = 0; i < 4; i++) txn_rand(1, 1, 0, 0, 0);

    // alu_done after 3 stall cycles, 4 BUSY cycles
    txn_rand(1, 0, 3, 0, 0);
    // done on the last watchdog cycle wins
    txn_rand(0, 1, TO - 1, 0, 0);
    // alu_done never arrives: watchdog error after 16 BUSY cycles
    txn_rand(0, 1, 99, 0, 0);
    txn_rand(1, 1, 40, 1, 0);

    // port 1 response held for 5 cycles with port 0 requesting
    txn_rand(0, 1, 0, 5, 0);

    // reset in BUSY, then a tie goes to port 0
    txn_rand(1, 0, 2, 0, 1);
    txn_rand(1, 1, 0, 0, 0);
    // reset in RESP, then a tie goes to port 0
    txn_rand(0, 1, 1, 3, 2);
    txn_rand(1, 1, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int p, d;
      p = $urandom_range(1, 3);
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 3);
      txn_rand(p[0], p[1], d, $urandom_range(0, 3), 0);
    end

    @(negedge clk);
    clear_inputs();
    #1;
    chk("final_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
